// File: rtl/init_step_sequencer_pkg.sv
// rtl/init_step_sequencer_pkg.sv - shared types and step-selection helpers for the init sequencer
package init_seq_pkg;

    // Widest step mask the selection helper can scan; step codes must fit below this.
    localparam int MAX_STEPS = 32;
    localparam int IDX_W     = 6;
    localparam int CODE_IDLE = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Result of a mask scan: found=0 means no runnable step remains.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } step_sel_t;

    // ctrl_I value presented in the DONE cycle.
    function automatic int done_code(input int num_steps);
        return num_steps + 1;
    endfunction

    // Lowest index >= cur whose skip bit is clear. Unused upper mask bits must be
    // set by the caller so the scan never runs past the last real step.
    function automatic step_sel_t next_step(input logic [MAX_STEPS-1:0] mask,
                                            input logic [IDX_W-1:0]     cur);
        step_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = '0;
        for (int i = MAX_STEPS - 1; i >= 0; i--) begin
            if (i >= int'(cur) && !mask[i]) begin
                sel.found = 1'b1;
                sel.idx   = IDX_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/step_timeout_timer.sv
// rtl/step_timeout_timer.sv - per-step wait timer, flags the last allowed WAIT cycle
module step_timeout_timer #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit ENABLED = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] LAST = ENABLED ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] count;

    // Count enabled cycles; saturate at LAST so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (ENABLED && enable && count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is the cycle in which the counter shows LAST; a zero timeout never expires.
    assign expired = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/init_step_sequencer.sv
// rtl/init_step_sequencer.sv - walks numbered init steps through the write engine with skip, retry and error status
module init_step_sequencer
    import init_seq_pkg::*;
#(
    parameter int NUM_STEPS   = 11,
    parameter int CTRL_W      = 4,
    parameter int TIMEOUT_CYC = 1023,
    parameter int MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Inicio_I,
    input  logic                 Final_WR,
    input  logic [NUM_STEPS-1:0] skip_mask,
    output logic [CTRL_W-1:0]    ctrl_I,
    output logic                 step_req,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CTRL_W-1:0]    err_step
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CTRL_W-1:0] DONE_CODE = CTRL_W'(done_code(NUM_STEPS));
    localparam logic [CTRL_W-1:0] IDLE_CODE = CTRL_W'(CODE_IDLE);

    if (2 ** CTRL_W <= NUM_STEPS + 1) begin : g_bad_ctrl_w
        $error("init_step_sequencer: CTRL_W too narrow for NUM_STEPS+1");
    end
    if (NUM_STEPS < 1 || NUM_STEPS >= MAX_STEPS) begin : g_bad_num_steps
        $error("init_step_sequencer: NUM_STEPS out of range");
    end

    seq_state_t            state;
    logic [CTRL_W-1:0]     cur_code;
    logic [RETRY_W-1:0]    retry;
    logic [NUM_STEPS-1:0]  skip_q;
    logic                  timeout;

    logic [MAX_STEPS-1:0]  start_mask;
    logic [MAX_STEPS-1:0]  run_mask;
    step_sel_t             first_sel;
    step_sel_t             adv_sel;
    logic [CTRL_W-1:0]     first_code;
    logic [CTRL_W-1:0]     adv_code;

    // Pad masks with ones above the last step so the scan stops at NUM_STEPS.
    always_comb begin
        start_mask                  = '1;
        start_mask[NUM_STEPS-1:0]   = skip_mask;
        run_mask                    = '1;
        run_mask[NUM_STEPS-1:0]     = skip_q;
        first_sel  = next_step(start_mask, '0);
        adv_sel    = next_step(run_mask, IDX_W'(cur_code));
        first_code = CTRL_W'(first_sel.idx) + CTRL_W'(1);
        adv_code   = CTRL_W'(adv_sel.idx) + CTRL_W'(1);
    end

    step_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (timeout)
    );

    // Sequencer FSM; outputs are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur_code <= '0;
            retry    <= '0;
            skip_q   <= '0;
            ctrl_I   <= '0;
            step_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_step <= '0;
        end else begin
            step_req <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (Inicio_I) begin
                        skip_q   <= skip_mask;
                        error    <= 1'b0;
                        err_step <= '0;
                        retry    <= '0;
                        if (first_sel.found) begin
                            state    <= ST_ISSUE;
                            cur_code <= first_code;
                            ctrl_I   <= first_code;
                            step_req <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state    <= ST_DONE;
                            cur_code <= '0;
                            ctrl_I   <= DONE_CODE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    // An ack seen here belongs to the previous step and is dropped.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Final_WR) begin
                        // Ack beats a coincident timeout.
                        retry <= '0;
                        if (adv_sel.found) begin
                            state    <= ST_ISSUE;
                            cur_code <= adv_code;
                            ctrl_I   <= adv_code;
                            step_req <= 1'b1;
                        end else begin
                            state    <= ST_DONE;
                            cur_code <= '0;
                            ctrl_I   <= DONE_CODE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else if (timeout) begin
                        if (int'(retry) < MAX_RETRY) begin
                            state    <= ST_ISSUE;
                            retry    <= retry + RETRY_W'(1);
                            step_req <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            ctrl_I   <= IDLE_CODE;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_step <= cur_code;
                            retry    <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    ctrl_I <= IDLE_CODE;
                end
                default: begin
                    state  <= ST_IDLE;
                    ctrl_I <= IDLE_CODE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
